// File: rtl/demux_pkg.sv
// Shared types and default parameters for the slot-router demultiplexer.
package demux_pkg;

    localparam int N_OUT_DEF = 31;
    localparam int W_DEF     = 2;
    localparam int SEL_W_DEF = 5;
    localparam int ERRCNT_W  = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One output holding slot: a data register plus its EMPTY/FULL occupancy FSM.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   SLOT_EMPTY | no unconsumed beat; a write fills the slot
//   SLOT_FULL  | beat held until acked; write + same-cycle ack replaces it
module demux_slot
    import demux_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] data
);

    slot_state_t  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    // State and data registers; reset empties the slot at once, without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next-state: a write always wins over an ack, so write+ack keeps the slot full.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (wr_en) begin
                    state_d = SLOT_FULL;
                    data_d  = wr_data;
                end
            end
            SLOT_FULL: begin
                if (wr_en) begin
                    data_d = wr_data;
                end else if (ack) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign valid = (state_q == SLOT_FULL);
    assign data  = data_q;

endmodule

// File: rtl/demux_slot_router.sv
// Registered 1-to-N_OUT demultiplexer with per-slot backpressure.
// Out-of-range selects are accepted, discarded and flagged on drop_pulse.
// Optional build macro DEMUX_ERRCNT_EN adds a saturating drop counter (err_cnt).
module demux_slot_router
    import demux_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int W     = W_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [W-1:0]       in_data,
    output logic [N_OUT*W-1:0] out_data,
    output logic [N_OUT-1:0]   out_valid,
    input  logic [N_OUT-1:0]   out_ack,
    output logic               drop_pulse
`ifdef DEMUX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt
`endif
);

    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] wr_en;
    logic             sel_in_range;
    logic             accept;
    logic             drop;
    logic             drop_pulse_q, drop_pulse_d;

    // Select decode and ready mux; purely combinational from in_sel/out_ack.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
        sel_in_range = |sel_hit;
        in_ready     = sel_in_range ? |(sel_hit & (~out_valid | out_ack)) : 1'b1;
        accept       = in_valid & in_ready;
        wr_en        = accept ? sel_hit : '0;
        drop         = accept & ~sel_in_range;
        drop_pulse_d = drop;
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(.W(W)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[k]),
            .wr_data (in_data),
            .ack     (out_ack[k]),
            .valid   (out_valid[k]),
            .data    (out_data[k*W +: W])
        );
    end

    // Drop flag registered so it shows for the cycle after the discarded beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_pulse_q <= 1'b0;
        else     drop_pulse_q <= drop_pulse_d;
    end

    assign drop_pulse = drop_pulse_q;

`ifdef DEMUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating drop counter; only reset clears it.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (drop && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux_slot_router.sv
module tb_demux_slot_router;

    localparam int NO = 31;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_sel;
    logic [1:0]    in_data;
    logic [NO*2-1:0] out_data;
    logic [NO-1:0] out_valid;
    logic [NO-1:0] out_ack;
    logic          drop_pulse;
`ifdef DEMUX_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    demux_slot_router dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .drop_pulse (drop_pulse)
`ifdef DEMUX_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: slot occupancy, slot contents, last-cycle drop, drop count.
    bit         mv[NO];
    logic [1:0] md[NO];
    bit         m_drop;
    int         m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NO; k++) begin
            mv[k] = 1'b0;
            md[k] = 2'b00;
        end
        m_drop = 1'b0;
        m_err  = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [NO-1:0]   ev;
        logic [NO*2-1:0] ed;
        for (int k = 0; k < NO; k++) begin
            ev[k]         = mv[k];
            ed[k*2 +: 2]  = md[k];
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, ".out_data"}, 64'(out_data), 64'(ed));
        chk({tag, ".drop_pulse"}, 64'(drop_pulse), 64'(m_drop));
`ifdef DEMUX_ERRCNT_EN
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_err));
`endif
    endtask

    // One clock of stimulus: drive after negedge, check ready, update model at posedge, check.
    task automatic step(input string tag, input logic v, input logic [4:0] s,
                        input logic [1:0] d, input logic [NO-1:0] a);
        logic exp_rdy;
        logic acc;
        @(negedge clk);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        out_ack  = a;
        #1;
        exp_rdy = (s >= 5'(NO)) ? 1'b1 : (!mv[s] || a[s]);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        acc    = v && exp_rdy;
        m_drop = acc && (s >= 5'(NO));
        if (m_drop && m_err < 255) m_err++;
        for (int k = 0; k < NO; k++) if (a[k]) mv[k] = 1'b0;
        if (acc && s < 5'(NO)) begin
            mv[s] = 1'b1;
            md[s] = d;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [NO*2-1:0] exp_d;
        logic [1:0]      d12;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sel   = '0;
        in_data  = '0;
        out_ack  = '0;
        model_reset();
        #1;
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        check_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill every slot with sel[1:0].
        for (int s = 0; s < NO; s++) step("fill", 1'b1, 5'(s), 2'(s), '0);
        for (int k = 0; k < NO; k++) exp_d[k*2 +: 2] = 2'(k % 4);
        chk("fill.all_valid", 64'(out_valid), 64'h7FFF_FFFF);
        chk("fill.all_data", 64'(out_data), 64'(exp_d));

        // Backpressure on slot 5.
        step("bp_load", 1'b1, 5'd5, 2'b10, NO'(1) << 5);
        step("bp_block", 1'b1, 5'd5, 2'b01, '0);
        chk("bp.hold", 64'(out_data[5*2 +: 2]), 64'd2);
        step("bp_replace", 1'b1, 5'd5, 2'b01, NO'(1) << 5);
        chk("bp.new_data", 64'(out_data[5*2 +: 2]), 64'd1);
        chk("bp.valid", 64'(out_valid[5]), 64'd1);

        // Out of range: 30 (stored, with ack to make room), 31, 31.
        exp_d = out_data;
        exp_d[30*2 +: 2] = 2'b11;
        step("oor30", 1'b1, 5'd30, 2'b11, NO'(1) << 30);
        step("oor31a", 1'b1, 5'd31, 2'b00, '0);
        chk("oor.pulse1", 64'(drop_pulse), 64'd1);
        step("oor31b", 1'b1, 5'd31, 2'b01, '0);
        chk("oor.pulse2", 64'(drop_pulse), 64'd1);
        chk("oor.slots", 64'(out_data), 64'(exp_d));
`ifdef DEMUX_ERRCNT_EN
        chk("oor.err_cnt", 64'(err_cnt), 64'd2);
`endif
        step("oor_idle", 1'b0, 5'd31, 2'b00, '0);
        chk("oor.pulse_end", 64'(drop_pulse), 64'd0);

        // Saturation.
        for (int i = 0; i < 300; i++) step("sat", 1'b1, 5'd31, 2'(i), '0);
`ifdef DEMUX_ERRCNT_EN
        chk("sat.err_cnt", 64'(err_cnt), 64'd255);
`endif

        // Multi-ack with write to slot 12.
        for (int s = 0; s < NO; s++) step("mfill", 1'b1, 5'(s), 2'($urandom), NO'(1) << s);
        chk("multi.pre_full", 64'(out_valid), 64'h7FFF_FFFF);
        d12 = ~md[12];
        step("multi", 1'b1, 5'd12, d12, '1);
        chk("multi.valid", 64'(out_valid), 64'(NO'(1) << 12));
        chk("multi.data12", 64'(out_data[12*2 +: 2]), 64'(d12));

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                 2'($urandom), NO'($urandom & $urandom & $urandom));

        // Async reset mid-stream with exactly 10 slots full.
        step("drain", 1'b0, 5'd0, 2'b00, '1);
        for (int s = 0; s < 10; s++) step("ten", 1'b1, 5'(s * 3), 2'b11, '0);
        chk("ten.valid", 64'($countones(out_valid)), 64'd10);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async.out_valid", 64'(out_valid), 64'd0);
        chk("async.out_data", 64'(out_data), 64'd0);
        chk("async.in_ready", 64'(in_ready), 64'd1);
        check_outputs("async");
        @(negedge clk);
        in_valid = 1'b0;
        out_ack  = '0;
        rst      = 1'b0;
        step("post_rst", 1'b1, 5'd7, 2'b10, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
